// File: rtl/mem_access.sv
// mem_access -- MEM stage of the 5-stage RV32I pipeline.
//
// Takes the EX/MEM latch outputs and performs the load or store, if any, over
// an 8-bit memory-controller port. Each byte is one request/ack handshake, and
// bytes go in little-endian order. Load data is sign- or zero-extended, then
// the writeback triple goes to MEM/WB. mem_stall holds the pipeline until the
// access is complete.
//
// Optional feature (compile-time macro MEM_MISALIGN_TRAP_EN):
//   When defined, a misaligned half/word access issues no memory requests.
//   It goes straight to the completion cycle and raises misalign_o there.
//   When undefined, there is no misalign_o port and every address is accessed
//   bytewise.
//
// Parameters:
//   ADDR_W       width of memaddr_i / mem_addr_o
//
// Ports:
//   clk, rst     clock; synchronous active-high reset (outputs forced to 0
//                while rst is high)
//   wd_i         destination register from EX/MEM
//   wreg_i       register write enable from EX/MEM
//   wdata_i      ALU result, or store data for stores
//   memaddr_i    effective address
//   memwr_i      0 load, 1 store
//   memcnf_i     0 none, 1 byte, 2 half, 3 word
//   memsigned_i  1 sign-extend load data, 0 zero-extend
//   mem_req_o    byte request to the memory controller
//   mem_wr_o     request direction, 1 = write
//   mem_addr_o   byte address
//   mem_dout_o   write byte
//   mem_din_i    read byte, valid while mem_ack_i is high
//   mem_ack_i    one-cycle completion pulse for the current byte
//   wd_o         writeback register
//   wreg_o       writeback enable
//   wdata_o      writeback data
//   mem_stall    stall request to pipeline control
//   misalign_o   misaligned access flag (only with MEM_MISALIGN_TRAP_EN)
module mem_access #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] memaddr_i,
  input  logic              memwr_i,
  input  logic [1:0]        memcnf_i,
  input  logic              memsigned_i,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i,
  input  logic              mem_ack_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              mem_stall
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;

  logic [1:0]  last_idx;
  logic [31:0] load_ext;

  // Index of the final byte: 1/2/4 bytes for byte/half/word.
  always_comb begin
    unique case (memcnf_i)
      2'd1:    last_idx = 2'd0;
      2'd2:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // Extend the assembled load data according to access size and signedness.
  always_comb begin
    unique case (memcnf_i)
      2'd1:    load_ext = {{24{memsigned_i & buf_q[7]}}, buf_q[7:0]};
      2'd2:    load_ext = {{16{memsigned_i & buf_q[15]}}, buf_q[15:0]};
      default: load_ext = buf_q;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic misaligned;

  assign misaligned = ((memcnf_i == 2'd2) && memaddr_i[0]) ||
                      ((memcnf_i == 2'd3) && (memaddr_i[1:0] != 2'b00));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (memcnf_i != 2'd0) begin
          cnt_d   = '0;
          buf_d   = '0;
          state_d = S_ACCESS;
`ifdef MEM_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      S_ACCESS: begin
        if (mem_ack_i) begin
          if (!memwr_i) begin
            buf_d[8*cnt_q +: 8] = mem_din_i;
          end
          if (cnt_q == last_idx) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    mem_req_o  = 1'b0;
    mem_wr_o   = 1'b0;
    mem_addr_o = '0;
    mem_dout_o = '0;
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    mem_stall  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_o = 1'b0;
`endif
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          wd_o = wd_i;
          if (memcnf_i == 2'd0) begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end else begin
            mem_stall = 1'b1;
          end
        end
        S_ACCESS: begin
          mem_req_o  = 1'b1;
          mem_wr_o   = memwr_i;
          mem_addr_o = memaddr_i + ADDR_W'(cnt_q);
          mem_dout_o = wdata_i[8*cnt_q +: 8];
          mem_stall  = 1'b1;
          wd_o       = wd_i;
        end
        S_DONE: begin
          wd_o = wd_i;
          if (!memwr_i) begin
            wreg_o  = wreg_i;
            wdata_o = load_ext;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          if (mis_q) begin
            misalign_o = 1'b1;
            wreg_o     = 1'b0;
            wdata_o    = '0;
          end
`endif
        end
        default: begin
          mem_stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] memaddr_i;
  logic        memwr_i;
  logic [1:0]  memcnf_i;
  logic        memsigned_i;
  logic        mem_req_o;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_dout_o;
  logic [7:0]  mem_din_i;
  logic        mem_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        mem_stall;
  logic        mis;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .memaddr_i  (memaddr_i),
    .memwr_i    (memwr_i),
    .memcnf_i   (memcnf_i),
    .memsigned_i(memsigned_i),
    .mem_req_o  (mem_req_o),
    .mem_wr_o   (mem_wr_o),
    .mem_addr_o (mem_addr_o),
    .mem_dout_o (mem_dout_o),
    .mem_din_i  (mem_din_i),
    .mem_ack_i  (mem_ack_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .mem_stall  (mem_stall)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o (mis)
`endif
  );

`ifndef MEM_MISALIGN_TRAP_EN
  assign mis = 1'b0;
`endif

  // One record per clock cycle: inputs to apply plus the outputs expected.
  typedef struct {
    string       tag;
    logic        rst;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  cnf;
    logic        sgn;
    logic        ack;
    logic [7:0]  din;
    logic        e_stall;
    logic        e_req;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [7:0]  e_dout;
    int unsigned wbmode;   // 0 unchecked, 1 wreg_o must be 0, 2 full triple
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_mis;
    logic        is_done;
  } cyc_t;

  cyc_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          stallcnt;
  logic [31:0] last_done_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cyc_t base_rec(input string tag, input logic [4:0] wd, input logic wreg,
                                    input logic [31:0] wdata, input logic [31:0] addr,
                                    input logic wr, input logic [1:0] cnf, input logic sgn);
    cyc_t r;
    r.tag = tag; r.rst = 1'b0; r.wd = wd; r.wreg = wreg; r.wdata = wdata; r.addr = addr;
    r.wr = wr; r.cnf = cnf; r.sgn = sgn; r.ack = 1'b0; r.din = 8'h00;
    r.e_stall = 1'b0; r.e_req = 1'b0; r.e_wr = 1'b0; r.e_addr = '0; r.e_dout = '0;
    r.wbmode = 0; r.e_wd = '0; r.e_wreg = 1'b0; r.e_wdata = '0; r.e_mis = 1'b0;
    r.is_done = 1'b0;
    return r;
  endfunction

  task automatic push_reset(input string tag);
    cyc_t r;
    r = base_rec(tag, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    r.rst = 1'b1;
    r.wbmode = 2;
    q.push_back(r);
  endtask

  // Behavioural model of one instruction through the MEM stage.
  // rbytes holds the bytes memory returns, byte k at bits 8k+7:8k.
  // abort_at: number of acked bytes after which reset is asserted (>=4: never).
  task automatic build_op(input string tag, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic [31:0] addr, input logic wr,
                          input logic [1:0] cnf, input logic sgn, input int unsigned dly,
                          input logic [31:0] rbytes, input logic noise, input int unsigned abort_at);
    cyc_t r;
    int unsigned n;
    longint val;
    logic trap;
    r = base_rec(tag, wd, wreg, wdata, addr, wr, cnf, sgn);
    if (cnf == 2'd0) begin
      r.wbmode = 2; r.e_wd = wd; r.e_wreg = wreg; r.e_wdata = wdata;
      r.ack = noise; r.din = 8'hEE;
      q.push_back(r);
      return;
    end
    n = (cnf == 2'd1) ? 1 : (cnf == 2'd2) ? 2 : 4;
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (n == 2 && (addr % 2) != 0) || (n == 4 && (addr % 4) != 0);
`endif
    // detection cycle
    r.e_stall = 1'b1; r.wbmode = 1; r.ack = noise; r.din = 8'hEE;
    q.push_back(r);
    val = 0;
    if (!trap) begin
      for (int unsigned k = 0; k < n; k++) begin
        if (k == abort_at) begin
          push_reset({tag, "_rst"});
          return;
        end
        for (int unsigned d = 0; d <= dly; d++) begin
          r = base_rec(tag, wd, wreg, wdata, addr, wr, cnf, sgn);
          r.e_stall = 1'b1; r.e_req = 1'b1; r.e_wr = wr;
          r.e_addr = addr + k;
          r.e_dout = 8'((wdata >> (8 * k)) & 32'hFF);
          r.wbmode = 1;
          if (d == dly) begin
            r.ack = 1'b1;
            r.din = 8'((rbytes >> (8 * k)) & 32'hFF);
          end else begin
            r.din = 8'h5A;
          end
          q.push_back(r);
        end
        val += longint'((rbytes >> (8 * k)) & 32'hFF) << (8 * k);
      end
    end
    if (sgn && n < 4 && val >= (longint'(1) << (8 * n - 1)))
      val -= longint'(1) << (8 * n);
    r = base_rec(tag, wd, wreg, wdata, addr, wr, cnf, sgn);
    r.is_done = 1'b1; r.wbmode = 2; r.e_wd = wd;
    r.ack = noise; r.din = 8'hEE;
    if (trap) begin
      r.e_mis = 1'b1;
    end else if (!wr) begin
      r.e_wreg = wreg;
      r.e_wdata = 32'(val);
    end
    q.push_back(r);
  endtask

  // Drive and compare every queued cycle.
  task automatic run_queue();
    cyc_t r;
    stallcnt = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      rst = r.rst; wd_i = r.wd; wreg_i = r.wreg; wdata_i = r.wdata; memaddr_i = r.addr;
      memwr_i = r.wr; memcnf_i = r.cnf; memsigned_i = r.sgn; mem_ack_i = r.ack;
      mem_din_i = r.din;
      @(negedge clk);
      chk({r.tag, ".stall"}, 32'(mem_stall), 32'(r.e_stall));
      chk({r.tag, ".req"}, 32'(mem_req_o), 32'(r.e_req));
      if (r.e_req || r.rst) begin
        chk({r.tag, ".wr"}, 32'(mem_wr_o), 32'(r.e_wr));
        chk({r.tag, ".addr"}, mem_addr_o, r.e_addr);
        chk({r.tag, ".dout"}, 32'(mem_dout_o), 32'(r.e_dout));
      end
      if (r.wbmode >= 1) chk({r.tag, ".wreg"}, 32'(wreg_o), 32'(r.e_wreg));
      if (r.wbmode == 2) begin
        chk({r.tag, ".wd"}, 32'(wd_o), 32'(r.e_wd));
        chk({r.tag, ".wdata"}, wdata_o, r.e_wdata);
      end
`ifdef MEM_MISALIGN_TRAP_EN
      chk({r.tag, ".mis"}, 32'(mis), 32'(r.e_mis));
`endif
      if (mem_stall === 1'b1) stallcnt++;
      if (r.is_done) last_done_wdata = wdata_o;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wd_i = '0; wreg_i = 1'b0; wdata_i = '0; memaddr_i = '0; memwr_i = 1'b0;
    memcnf_i = '0; memsigned_i = 1'b0; mem_ack_i = 1'b0; mem_din_i = '0;

    push_reset("reset0");
    push_reset("reset1");
    build_op("pass", 5'd5, 1'b1, 32'h1234, 32'h0, 1'b0, 2'd0, 1'b0, 0, 32'h0, 1'b1, 9);
    run_queue();

    build_op("lw", 5'd7, 1'b1, 32'hCAFEF00D, 32'h100, 1'b0, 2'd3, 1'b0, 0, 32'h12345678, 1'b0, 9);
    run_queue();
    chk("lw_stall_cycles", 32'(stallcnt), 32'd5);
    chk("lw_value", last_done_wdata, 32'h12345678);

    build_op("lb", 5'd3, 1'b1, 32'h0, 32'h20, 1'b0, 2'd1, 1'b1, 0, 32'h80, 1'b0, 9);
    run_queue();
    chk("lb_value", last_done_wdata, 32'hFFFFFF80);

    build_op("lhu", 5'd4, 1'b1, 32'h0, 32'h22, 1'b0, 2'd2, 1'b0, 0, 32'hFF80, 1'b0, 9);
    run_queue();
    chk("lhu_value", last_done_wdata, 32'h0000FF80);

    build_op("sh", 5'd9, 1'b1, 32'hAABBCCDD, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0, 3, 32'h0, 1'b0, 9);
    run_queue();
    chk("sh_stall_cycles", 32'(stallcnt), 32'd9);

    build_op("lh", 5'd11, 1'b1, 32'h0, 32'h40, 1'b0, 2'd2, 1'b1, 1, 32'h9234, 1'b1, 9);
    run_queue();
    chk("lh_value", last_done_wdata, 32'hFFFF9234);

    build_op("sw", 5'd12, 1'b1, 32'h01020304, 32'h200, 1'b1, 2'd3, 1'b0, 1, 32'h0, 1'b0, 9);
    build_op("lbu", 5'd13, 1'b1, 32'h0, 32'h7, 1'b0, 2'd1, 1'b0, 2, 32'hF0, 1'b0, 9);
    run_queue();
    chk("lbu_value", last_done_wdata, 32'h000000F0);

    build_op("sw_abort", 5'd14, 1'b0, 32'h11223344, 32'h300, 1'b1, 2'd3, 1'b0, 0, 32'h0, 1'b0, 1);
    build_op("lw_after", 5'd15, 1'b1, 32'h0, 32'h300, 1'b0, 2'd3, 1'b0, 0, 32'h04030201, 1'b0, 9);
    run_queue();
    chk("lw_after_value", last_done_wdata, 32'h04030201);

    // Misaligned word: trapped when the feature is built in, accessed otherwise.
    build_op("lw_mis", 5'd16, 1'b1, 32'h0, 32'h102, 1'b0, 2'd3, 1'b0, 0, 32'hDEADBEEF, 1'b0, 9);
    build_op("lh_mis", 5'd17, 1'b1, 32'h0, 32'h101, 1'b0, 2'd2, 1'b1, 0, 32'h8001, 1'b0, 9);
    build_op("pass2", 5'd18, 1'b0, 32'h55AA55AA, 32'h0, 1'b0, 2'd0, 1'b0, 0, 32'h0, 1'b0, 9);
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage RV32I pipeline; consumes the EX/MEM latch outputs: destination reg, write enable, result/store data, address, direction, size, signedness.
- Performs loads and stores over the 8-bit memory-controller port, one byte per handshake, little-endian.
- Sign/zero-extends load data and forwards the writeback triple to MEM/WB.
- Holds the pipeline via mem_stall until the access completes.

Parameters:
- ADDR_W, 32, width of memaddr_i / mem_addr_o.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wd_i  in  5  destination register from EX/MEM
- wreg_i  in  1  register write enable from EX/MEM
- wdata_i  in  32  ALU result (non-mem ops) or store data (stores)
- memaddr_i  in  ADDR_W  effective address
- memwr_i  in  1  0 load, 1 store
- memcnf_i  in  2  0 no mem op, 1 byte, 2 half, 3 word
- memsigned_i  in  1  1 sign-extend load, 0 zero-extend
- mem_req_o  out  1  byte request to memory controller
- mem_wr_o  out  1  request direction, 1 = write
- mem_addr_o  out  ADDR_W  byte address
- mem_dout_o  out  8  write byte
- mem_din_i  in  8  read byte, valid in the cycle mem_ack_i is high
- mem_ack_i  in  1  one-cycle completion pulse for the current byte
- wd_o  out  5  writeback register
- wreg_o  out  1  writeback enable
- wdata_o  out  32  writeback data
- mem_stall  out  1  stall request to pipeline control

Behaviour:
- Byte count N: memcnf 1/2/3 gives 1/2/4. Byte k address = memaddr_i + k, modulo 2^ADDR_W. No alignment check unless the optional feature below is enabled.
- States: IDLE, ACCESS, DONE. Byte counter cnt is 2 bits. Load assembly register buf is 32 bits.
- IDLE, memcnf_i == 0:
  - Pure pass-through: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, mem_stall=0, mem_req_o=0.
- IDLE, memcnf_i != 0:
  - mem_stall=1 combinationally, mem_req_o=0, wreg_o=0.
  - Next state ACCESS; cnt=0, buf=0.
- ACCESS:
  - mem_req_o=1, mem_wr_o=memwr_i, mem_addr_o=memaddr_i+cnt.
  - mem_dout_o = wdata_i[8*cnt+7 : 8*cnt].
  - mem_stall=1, wreg_o=0.
  - On mem_ack_i: if a load, buf byte cnt <= mem_din_i. If cnt==N-1, go to DONE; else cnt increments.
  - Without ack: state, cnt and all request outputs are held stable.
- DONE (exactly one cycle):
  - mem_stall=0, mem_req_o=0, wd_o=wd_i.
  - Load: wreg_o=wreg_i; wdata_o = buf extended from bit 7 (B) or bit 15 (H), sign- or zero-extended per memsigned_i; W taken as-is.
  - Store: wreg_o=0, wdata_o=0.
  - Next state IDLE.
- Upstream holds all *_i stable while mem_stall=1. The instruction advances on the DONE edge, so the same op is never reissued.
- mem_ack_i outside ACCESS is ignored.
- Reset:
  - While rst=1, all outputs are forced to 0 combinationally.
  - On the edge: state=IDLE, cnt=0, buf=0.
  - Reset during ACCESS abandons the transfer; no further requests are issued.
- Minimum latency: N+1 cycles when ack returns in the same cycle as the request (ACCESS ×N plus DONE), plus the 1 IDLE detection cycle.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Adds output misalign_o (1 bit).
  - A half access with memaddr_i[0]=1, or a word access with memaddr_i[1:0]!=0, issues no requests: IDLE goes directly to DONE.
  - In that DONE cycle: misalign_o=1, wreg_o=0, wdata_o=0. misalign_o is 0 otherwise, and 0 at reset.
- Undefined: no misalign_o port; every address is accessed bytewise as above.

Test Plan:
- Non-mem op: memcnf=0, wd=5, wreg=1, wdata=0x1234 -> same cycle wd_o=5, wreg_o=1, wdata_o=0x1234, mem_stall=0, mem_req_o=0.
- LW at 0x100, immediate acks, bytes 0x78,0x56,0x34,0x12 -> addresses 0x100..0x103 in order; DONE wdata_o=0x12345678, wreg_o=1; mem_stall high exactly 5 cycles.
- LB signed at 0x20 reading 0x80 -> wdata_o=0xFFFFFF80. LHU at 0x22 reading 0x80,0xFF -> wdata_o=0x0000FF80.
- SH at 0xFFFFFFFF with wdata_i=0xAABBCCDD, ack delayed 3 cycles per byte -> mem_dout_o 0xDD @0xFFFFFFFF, then 0xCC @0x00000000 (wrap); request outputs stable while waiting; DONE wreg_o=0.
- rst asserted after byte 1 of an SW -> mem_req_o=0 from that cycle, state IDLE; a following LW restarts at cnt=0.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> no mem_req_o; next cycle misalign_o=1, mem_stall=0, wreg_o=0.
